// File: rtl/mem_responder.sv
// Unified instruction/data memory responder: captures a word request, waits WAIT_CYCLES, then answers with a one-cycle ready.
// Optional MEM_MISALIGN_TRAP_EN turns non-word-aligned addresses into access faults.
module mem_responder #(
  parameter int          DEPTH       = 256,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int          IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [32:0] SPAN     = 33'(DEPTH) * 33'd4;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic [3:0]  be_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic        ready_r;
  logic        err_r;
  logic [31:0] rdata_r;
  logic        ready_s;
  logic        err_s;
  logic [31:0] rdata_s;
  logic        acc_we_s;
  logic [31:0] acc_addr_s;
  logic [31:0] off_s;
  logic [IDX_W-1:0] idx_s;
  logic        misalign_s;
  logic        fault_s;

  logic [31:0] mem [DEPTH];

  // Keep enabled byte lanes from the new word, the rest from the old one.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  // The response is decided on the edge that enters RESP; with zero wait states that is the acceptance edge.
  assign acc_we_s   = (state_r == ST_IDLE) ? we : we_r;
  assign acc_addr_s = (state_r == ST_IDLE) ? address : addr_r;
  assign off_s      = acc_addr_s - BASE_ADDR;
  assign idx_s      = off_s[IDX_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_s = |acc_addr_s[1:0];
`else
  assign misalign_s = 1'b0;
`endif

  assign fault_s = ({1'b0, off_s} >= SPAN) || misalign_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          next_state_s = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) begin
          next_state_s = ST_RESP;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Response values to be registered on the edge entering RESP.
  always_comb begin
    ready_s = 1'b0;
    err_s   = 1'b0;
    rdata_s = 32'h0000_0000;
    if (next_state_s == ST_RESP) begin
      ready_s = 1'b1;
      err_s   = fault_s;
      if (!fault_s && !acc_we_s) begin
        rdata_s = mem[idx_s];
      end else begin
        rdata_s = 32'h0000_0000;
      end
    end else begin
      ready_s = 1'b0;
      err_s   = 1'b0;
      rdata_s = 32'h0000_0000;
    end
  end

  // Wait counter and captured request copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      be_r    <= 4'b0000;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else if (state_r == ST_IDLE && req) begin
      cnt_r   <= CNT_LOAD;
      we_r    <= we;
      be_r    <= be;
      addr_r  <= address;
      wdata_r <= wdata;
    end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
      cnt_r <= cnt_r - 4'd1;
    end
  end

  // Registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= ready_s;
      err_r   <= err_s;
      rdata_r <= rdata_s;
    end
  end

  // Write commit on the edge leaving RESP; a reset on that edge still discards it.
  always_ff @(posedge clk) begin
    if (!reset && state_r == ST_RESP && we_r && !fault_s) begin
      mem[idx_s] <= merge_bytes(mem[idx_s], wdata_r, be_r);
    end
  end

  assign ready = ready_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (DEPTH=256, WAIT_CYCLES=2, BASE_ADDR=0).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = 4'b0000;
  logic [31:0] address = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_responder dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .be(be),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err)
  );

  always #5 clk = ~clk;

  // Issue one request, scramble the inputs after acceptance, and wait (bounded) for ready.
  task automatic txn(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, output logic [31:0] rd, output logic er,
                     output int lat);
    @(negedge clk);
    req = 1'b1; we = w; be = b; address = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = ~w; be = ~b; address = 32'h5A5A_5A5A; wdata = ~d;
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i; rd = rdata; er = err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", ready); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h expected 00000000", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ready !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL idle_no_ready: got %0d ready cycles expected 0", seen); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'b1111, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 00000000", rd); end
    @(negedge clk);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ready_pulse: got %b expected 0", ready); end
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", er); end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'b0001, 32'h10, 32'h0000_00AA, rd, er, lat);
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL be_0001: got %h expected deadbeaa", rd); end
    txn(1'b1, 4'b1111, 32'h14, 32'hA5A5_A5A5, rd, er, lat);
    txn(1'b1, 4'b0110, 32'h14, 32'h1122_3344, rd, er, lat);
    txn(1'b0, 4'b0000, 32'h14, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hA522_33A5) begin errors++; $display("FAIL be_0110: got %h expected a52233a5", rd); end
    txn(1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL be_0000_err: got %b expected 0", er); end
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL be_0000_noop: got %h expected deadbeaa", rd); end
  endtask

  task automatic test_back_to_back();
    int n_ready; int last; int bad_gap; int bad_data;
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'b0000; address = 32'h10; wdata = 32'h0;
    n_ready = 0; last = -1; bad_gap = 0; bad_data = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ready) begin
        n_ready++;
        if (last >= 0 && (i - last) != 4) bad_gap++;
        if (rdata !== 32'hDEAD_BEAA) bad_data++;
        last = i;
      end
    end
    req = 1'b0;
    checks++; if (n_ready !== 5) begin errors++; $display("FAIL b2b_count: got %0d expected 5", n_ready); end
    checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_gap: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (bad_data !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad reads expected 0", bad_data); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_range();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'b1111, 32'h0, 32'hCAFE_F00D, rd, er, lat);
    txn(1'b0, 4'b0000, 32'h400, 32'h0, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 3", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b expected 1", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 00000000", rd); end
    txn(1'b1, 4'b1111, 32'h400, 32'h5555_5555, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b expected 1", er); end
    txn(1'b0, 4'b0000, 32'h0, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hCAFE_F00D) begin errors++; $display("FAIL oor_wr_alias: got %h expected cafef00d", rd); end
    txn(1'b1, 4'b1111, 32'h3FC, 32'h0BAD_C0DE, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL last_wr_err: got %b expected 0", er); end
    txn(1'b0, 4'b0000, 32'h3FC, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h0BAD_C0DE || er !== 1'b0) begin errors++; $display("FAIL last_rd: got %h err %b expected 0badc0de err 0", rd, er); end
    txn(1'b0, 4'b0000, 32'hFFFF_FFFC, 32'h0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL wrap_rd: got %h err %b expected 00000000 err 1", rd, er); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 4'b1111, 32'h11, 32'h1234_5678, rd, er, lat);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", er); end
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'hDEAD_BEAA) begin errors++; $display("FAIL mis_word: got %h expected deadbeaa", rd); end
`else
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL mis_err: got %b expected 0", er); end
    txn(1'b0, 4'b0000, 32'h10, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL mis_word: got %h expected 12345678", rd); end
`endif
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic er; int lat; int seen;
    txn(1'b1, 4'b1111, 32'h20, 32'h1111_1111, rd, er, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'b1111; address = 32'h20; wdata = 32'h2222_2222;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (ready) seen++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ready) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_ready: got %0d ready cycles expected 0", seen); end
    txn(1'b0, 4'b0000, 32'h20, 32'h0, rd, er, lat);
    checks++; if (rd !== 32'h1111_1111) begin errors++; $display("FAIL abort_data: got %h expected 11111111", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_back_to_back();
    test_range();
    test_misalign();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
